// File: rtl/cache_pkg.sv
// Shared types and sizing helpers for the set-associative data cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SWAP_OUT   = 2'd1,
    SWAP_IN    = 2'd2,
    SWAP_IN_OK = 2'd3
  } cache_state_t;

  localparam int REPL_FIFO = 0;
  localparam int REPL_LRU  = 1;
  localparam int WORD_W    = 32;

  function automatic int line_words(input int line_addr_len);
    return 1 << line_addr_len;
  endfunction

  function automatic int line_bits(input int line_addr_len);
    return WORD_W * line_words(line_addr_len);
  endfunction

  function automatic int mem_addr_w(input int tag_len, input int set_len);
    return tag_len + set_len;
  endfunction

  // A single-way cache still needs a one-bit way index.
  function automatic int way_idx_w(input int way_cnt);
    return (way_cnt > 1) ? $clog2(way_cnt) : 1;
  endfunction

endpackage

// File: rtl/cache_assoc_repl.sv
// Replacement state: per-set FIFO pointer and per-set LRU ages.
// Age WAY_CNT-1 is most recently used, age 0 is the eviction candidate.
// Both structures are kept up to date; REPL_POLICY only selects the victim.
module cache_repl
  import cache_pkg::*;
#(
  parameter int WAY_CNT      = 4,
  parameter int SET_ADDR_LEN = 3,
  parameter int REPL_POLICY  = REPL_FIFO,
  localparam int WW          = way_idx_w(WAY_CNT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SET_ADDR_LEN-1:0] query_set,
  output logic [WW-1:0]           victim_way,
  input  logic                    touch_en,
  input  logic [WW-1:0]           touch_way,
  input  logic [SET_ADDR_LEN-1:0] touch_set,
  input  logic                    fill_en,
  input  logic [WW-1:0]           fill_way,
  input  logic [SET_ADDR_LEN-1:0] fill_set,
  input  logic                    fill_by_policy
);

  localparam int SETS = 2 ** SET_ADDR_LEN;
  localparam logic [WW-1:0] WAY_MAX = WW'(WAY_CNT - 1);

  logic [WW-1:0]           fifo_ptr [SETS];
  logic [WW-1:0]           age      [SETS][WAY_CNT];
  logic                    upd_en;
  logic [WW-1:0]           upd_way;
  logic [SET_ADDR_LEN-1:0] upd_set;
  logic [WW-1:0]           upd_old;
  logic [WW-1:0]           oldest;

  // A hit touch and a fill never coincide; both mark the way most recently used.
  always_comb begin
    upd_en  = touch_en | fill_en;
    upd_way = touch_en ? touch_way : fill_way;
    upd_set = touch_en ? touch_set : fill_set;
    upd_old = age[upd_set][upd_way];
  end

  // Victim selection for the set being looked up.
  always_comb begin
    oldest = '0;
    for (int w = 0; w < WAY_CNT; w++) begin
      if (age[query_set][w] == '0) oldest = WW'(w);
    end
    victim_way = (REPL_POLICY == REPL_LRU) ? oldest : fifo_ptr[query_set];
  end

  // Age and pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        fifo_ptr[s] <= '0;
        for (int w = 0; w < WAY_CNT; w++) age[s][w] <= WW'(w);
      end
    end else begin
      if (upd_en) begin
        for (int w = 0; w < WAY_CNT; w++) begin
          if (WW'(w) == upd_way)            age[upd_set][w] <= WAY_MAX;
          else if (age[upd_set][w] > upd_old) age[upd_set][w] <= age[upd_set][w] - 1'b1;
        end
      end
      if (fill_en && fill_by_policy) begin
        fifo_ptr[fill_set] <= (fifo_ptr[fill_set] == WAY_MAX) ? '0 : fifo_ptr[fill_set] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_assoc.sv
// N-way set-associative write-back, write-allocate data cache.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
//
// state      | meaning
// IDLE       | lookup on live addr; hits served here
// SWAP_OUT   | writing dirty victim line back
// SWAP_IN    | fetching requested line
// SWAP_IN_OK | installing fetched line into victim way
module cache_assoc
  import cache_pkg::*;
#(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 3,
  parameter int TAG_ADDR_LEN  = 7,
  parameter int WAY_CNT       = 4,
  parameter int REPL_POLICY   = REPL_FIFO
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [31:0]                          addr,
  input  logic                                 rd_req,
  input  logic                                 wr_req,
  input  logic [31:0]                          wr_data,
  output logic [31:0]                          rd_data,
  output logic                                 miss,
  output logic [TAG_ADDR_LEN+SET_ADDR_LEN-1:0] mem_addr,
  output logic                                 mem_rd_req,
  output logic                                 mem_wr_req,
  output logic [32*(2**LINE_ADDR_LEN)-1:0]     mem_wr_line,
  input  logic [32*(2**LINE_ADDR_LEN)-1:0]     mem_rd_line,
  input  logic                                 mem_gnt
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                          hit_cnt,
  output logic [31:0]                          miss_cnt
`endif
);

  localparam int LW      = line_bits(LINE_ADDR_LEN);
  localparam int SETS    = 2 ** SET_ADDR_LEN;
  localparam int MAW     = mem_addr_w(TAG_ADDR_LEN, SET_ADDR_LEN);
  localparam int WW      = way_idx_w(WAY_CNT);
  localparam int ADDR_HI = TAG_ADDR_LEN + SET_ADDR_LEN + LINE_ADDR_LEN + 2;

  cache_state_t state_q, state_d;

  logic [LW-1:0]           data_q  [SETS][WAY_CNT];
  logic [TAG_ADDR_LEN-1:0] tag_q   [SETS][WAY_CNT];
  logic [WAY_CNT-1:0]      valid_q [SETS];
  logic [WAY_CNT-1:0]      dirty_q [SETS];

  logic [TAG_ADDR_LEN-1:0]  cur_tag;
  logic [SET_ADDR_LEN-1:0]  cur_set;
  logic [LINE_ADDR_LEN-1:0] cur_word;
  logic [LINE_ADDR_LEN+4:0] word_lsb;
  logic                     unused_addr;

  assign cur_word    = addr[LINE_ADDR_LEN+1:2];
  assign cur_set     = addr[SET_ADDR_LEN+LINE_ADDR_LEN+1:LINE_ADDR_LEN+2];
  assign cur_tag     = addr[ADDR_HI-1:SET_ADDR_LEN+LINE_ADDR_LEN+2];
  assign word_lsb    = {cur_word, 5'd0};
  assign unused_addr = ^{addr[31:ADDR_HI], addr[1:0]};

  logic [WAY_CNT-1:0] hit_vec;
  logic               hit;
  logic [WW-1:0]      hit_way;
  logic               inv_found;
  logic [WW-1:0]      inv_way;
  logic [WW-1:0]      repl_victim;
  logic [WW-1:0]      victim_sel;
  logic               victim_dirty;
  logic               req, serve, start_miss;

  logic [TAG_ADDR_LEN-1:0] lat_tag;
  logic [SET_ADDR_LEN-1:0] lat_set;
  logic [WW-1:0]           lat_way;
  logic                    lat_by_policy;
  logic [MAW-1:0]          vic_addr;
  logic [LW-1:0]           fill_line;

  // Tag compare, lowest invalid way, and victim choice for the live address.
  always_comb begin
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAY_CNT; w++) begin
      hit_vec[w] = valid_q[cur_set][w] && (tag_q[cur_set][w] == cur_tag);
      if (hit_vec[w]) hit_way = WW'(w);
    end
    for (int w = WAY_CNT - 1; w >= 0; w--) begin
      if (!valid_q[cur_set][w]) begin
        inv_found = 1'b1;
        inv_way   = WW'(w);
      end
    end
    hit          = $onehot(hit_vec);
    victim_sel   = inv_found ? inv_way : repl_victim;
    victim_dirty = valid_q[cur_set][victim_sel] & dirty_q[cur_set][victim_sel];
  end

  assign req        = rd_req | wr_req;
  assign serve      = (state_q == IDLE) && req && hit;
  assign start_miss = (state_q == IDLE) && req && !hit;
  assign miss       = req & ~(hit & (state_q == IDLE));

  cache_repl #(
    .WAY_CNT      (WAY_CNT),
    .SET_ADDR_LEN (SET_ADDR_LEN),
    .REPL_POLICY  (REPL_POLICY)
  ) u_repl (
    .clk            (clk),
    .rst            (rst),
    .query_set      (cur_set),
    .victim_way     (repl_victim),
    .touch_en       (serve),
    .touch_way      (hit_way),
    .touch_set      (cur_set),
    .fill_en        (state_q == SWAP_IN_OK),
    .fill_way       (lat_way),
    .fill_set       (lat_set),
    .fill_by_policy (lat_by_policy)
  );

  // Next state and memory-port outputs; requests follow state so reset drops them at once.
  always_comb begin
    state_d    = state_q;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    mem_addr   = '0;
    case (state_q)
      IDLE:       if (start_miss) state_d = victim_dirty ? SWAP_OUT : SWAP_IN;
      SWAP_OUT: begin
        mem_wr_req = 1'b1;
        mem_addr   = vic_addr;
        if (mem_gnt) state_d = SWAP_IN;
      end
      SWAP_IN: begin
        mem_rd_req = 1'b1;
        mem_addr   = {lat_tag, lat_set};
        if (mem_gnt) state_d = SWAP_IN_OK;
      end
      SWAP_IN_OK: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // State, status bits, read data and miss bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rd_data       <= '0;
      lat_tag       <= '0;
      lat_set       <= '0;
      lat_way       <= '0;
      lat_by_policy <= 1'b0;
      vic_addr      <= '0;
      fill_line     <= '0;
      mem_wr_line   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (serve) begin
        if (rd_req) rd_data <= data_q[cur_set][hit_way][word_lsb +: 32];
        else        dirty_q[cur_set][hit_way] <= 1'b1;
      end
      if (start_miss) begin
        lat_tag       <= cur_tag;
        lat_set       <= cur_set;
        lat_way       <= victim_sel;
        lat_by_policy <= !inv_found;
        if (victim_dirty) begin
          mem_wr_line <= data_q[cur_set][victim_sel];
          vic_addr    <= {tag_q[cur_set][victim_sel], cur_set};
        end
      end
      if (state_q == SWAP_IN && mem_gnt) fill_line <= mem_rd_line;
      if (state_q == SWAP_IN_OK) begin
        valid_q[lat_set][lat_way] <= 1'b1;
        dirty_q[lat_set][lat_way] <= 1'b0;
      end
    end
  end

  // Line and tag storage; contents are qualified by valid so no reset is needed.
  always_ff @(posedge clk) begin
    if (serve && !rd_req) data_q[cur_set][hit_way][word_lsb +: 32] <= wr_data;
    if (state_q == SWAP_IN_OK) begin
      data_q[lat_set][lat_way] <= fill_line;
      tag_q[lat_set][lat_way]  <= lat_tag;
    end
  end

`ifdef CACHE_STATS_EN
  // Saturating hit and miss counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (serve && hit_cnt != 32'hFFFF_FFFF)       hit_cnt  <= hit_cnt + 1'b1;
      if (start_miss && miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_assoc.sv
// Directed bench for cache_assoc: instance 0 uses FIFO, instance 1 uses LRU.
// Each instance has its own line-memory responder with a fixed grant latency.
module tb_cache_assoc;

  localparam int LW  = 256;
  localparam int MAW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]    addr_s [2];
  logic           rd_s   [2];
  logic           wr_s   [2];
  logic [31:0]    wd_s   [2];
  logic [31:0]    rdd_s  [2];
  logic           miss_s [2];
  logic [MAW-1:0] maddr_s[2];
  logic           mrd_s  [2];
  logic           mwr_s  [2];
  logic [LW-1:0]  mwl_s  [2];
  logic [LW-1:0]  mrl_s  [2];
  logic           gnt_s  [2];
`ifdef CACHE_STATS_EN
  logic [31:0]    hcnt_s [2];
  logic [31:0]    mcnt_s [2];
`endif

  cache_assoc #(.LINE_ADDR_LEN(3), .SET_ADDR_LEN(3), .TAG_ADDR_LEN(7), .WAY_CNT(4), .REPL_POLICY(0)) dut_fifo (
`ifdef CACHE_STATS_EN
    .hit_cnt(hcnt_s[0]), .miss_cnt(mcnt_s[0]),
`endif
    .clk(clk), .rst(rst), .addr(addr_s[0]), .rd_req(rd_s[0]), .wr_req(wr_s[0]), .wr_data(wd_s[0]),
    .rd_data(rdd_s[0]), .miss(miss_s[0]), .mem_addr(maddr_s[0]), .mem_rd_req(mrd_s[0]),
    .mem_wr_req(mwr_s[0]), .mem_wr_line(mwl_s[0]), .mem_rd_line(mrl_s[0]), .mem_gnt(gnt_s[0]));

  cache_assoc #(.LINE_ADDR_LEN(3), .SET_ADDR_LEN(3), .TAG_ADDR_LEN(7), .WAY_CNT(4), .REPL_POLICY(1)) dut_lru (
`ifdef CACHE_STATS_EN
    .hit_cnt(hcnt_s[1]), .miss_cnt(mcnt_s[1]),
`endif
    .clk(clk), .rst(rst), .addr(addr_s[1]), .rd_req(rd_s[1]), .wr_req(wr_s[1]), .wr_data(wd_s[1]),
    .rd_data(rdd_s[1]), .miss(miss_s[1]), .mem_addr(maddr_s[1]), .mem_rd_req(mrd_s[1]),
    .mem_wr_req(mwr_s[1]), .mem_wr_line(mwl_s[1]), .mem_rd_line(mrl_s[1]), .mem_gnt(gnt_s[1]));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Line memory model: untouched lines hold word k = C000_0000 | (line_addr << 8) | k.
  logic [LW-1:0] store0 [int];
  logic [LW-1:0] store1 [int];

  function automatic logic [LW-1:0] line_of(input int g, input logic [MAW-1:0] la);
    logic [LW-1:0] l;
    if (g == 0 && store0.exists(int'(la))) return store0[int'(la)];
    if (g == 1 && store1.exists(int'(la))) return store1[int'(la)];
    for (int k = 0; k < 8; k++) l[32*k +: 32] = 32'hC000_0000 | (32'(la) << 8) | 32'(k);
    return l;
  endfunction

  int             dly        [2] = '{0, 0};
  int             rd_cnt     [2] = '{0, 0};
  int             wr_cnt     [2] = '{0, 0};
  int             both_hi        = 0;
  logic [MAW-1:0] last_rd_addr[2];
  logic [MAW-1:0] last_wr_addr[2];
  logic [LW-1:0]  last_wr_line[2];

  initial begin
    for (int g = 0; g < 2; g++) begin
      addr_s[g] = '0; rd_s[g] = 1'b0; wr_s[g] = 1'b0; wd_s[g] = '0;
      mrl_s[g] = '0; gnt_s[g] = 1'b0;
      last_rd_addr[g] = '1; last_wr_addr[g] = '1; last_wr_line[g] = '0;
    end
  end

  // Responder: grant each request three cycles after it appears.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < 2; g++) begin
        gnt_s[g] <= 1'b0;
        dly[g]   <= 0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        gnt_s[g] <= 1'b0;
        if (mrd_s[g] && mwr_s[g]) both_hi <= both_hi + 1;
        if ((mrd_s[g] || mwr_s[g]) && !gnt_s[g]) begin
          if (dly[g] == 2) begin
            gnt_s[g] <= 1'b1;
            dly[g]   <= 0;
            if (mrd_s[g]) begin
              mrl_s[g]        <= line_of(g, maddr_s[g]);
              rd_cnt[g]       <= rd_cnt[g] + 1;
              last_rd_addr[g] <= maddr_s[g];
            end else begin
              if (g == 0) store0[int'(maddr_s[g])] = mwl_s[g];
              else        store1[int'(maddr_s[g])] = mwl_s[g];
              wr_cnt[g]       <= wr_cnt[g] + 1;
              last_wr_addr[g] <= maddr_s[g];
              last_wr_line[g] <= mwl_s[g];
            end
          end else begin
            dly[g] <= dly[g] + 1;
          end
        end
      end
    end
  end

  // Present a request, hold it until miss falls, let one edge serve it, then drop it.
  task automatic access(input int s, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, output bit was_miss, output logic [31:0] rdat);
    int n;
    @(negedge clk);
    addr_s[s] = a; rd_s[s] = rd; wr_s[s] = wr; wd_s[s] = d;
    #1;
    was_miss = miss_s[s];
    n = 0;
    while (miss_s[s] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (miss_s[s]) check("access_timeout", LW'(miss_s[s]), LW'(0));
    @(posedge clk);
    #1;
    rd_s[s] = 1'b0; wr_s[s] = 1'b0;
    rdat = rdd_s[s];
  endtask

  bit            m;
  logic [31:0]   r;
  logic [LW-1:0] exp_line;
  int            n;
  int            rd_before;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rd_data",   LW'(rdd_s[0]), LW'(0));
    check("rst_miss",      LW'(miss_s[0]), LW'(0));
    check("rst_mem_rd",    LW'(mrd_s[0]), LW'(0));
    check("rst_mem_wr",    LW'(mwr_s[1]), LW'(0));
    check("rst_mem_addr",  LW'(maddr_s[0]), LW'(0));
    check("rst_wr_line",   mwl_s[0], LW'(0));

    // Cold read of 0x0: miss while still in IDLE, then a line fetch from address 0.
    @(negedge clk);
    addr_s[0] = 32'h0; rd_s[0] = 1'b1;
    #1;
    check("cold_miss",       LW'(miss_s[0]), LW'(1));
    check("cold_idle_no_rd", LW'(mrd_s[0]), LW'(0));
    @(negedge clk);
    check("cold_swap_in_rd", LW'(mrd_s[0]), LW'(1));
    check("cold_swap_in_wr", LW'(mwr_s[0]), LW'(0));
    check("cold_mem_addr",   LW'(maddr_s[0]), LW'(0));
    n = 0;
    while (miss_s[0] && n < 200) begin @(negedge clk); n++; end
    if (miss_s[0]) check("cold_timeout", LW'(miss_s[0]), LW'(0));
    @(posedge clk); #1;
    rd_s[0] = 1'b0;
    check("cold_rd_data", LW'(rdd_s[0]), LW'(32'hC000_0000));

    // Write miss on 0x40 (set 2), then a read hit with no memory traffic.
    access(0, 0, 1, 32'h40, 32'hDEAD_BEEF, m, r);
    check("wr40_miss", LW'(m), LW'(1));
    rd_before = rd_cnt[0];
    access(0, 1, 0, 32'h40, 32'h0, m, r);
    check("rd40_hit",     LW'(m), LW'(0));
    check("rd40_data",    LW'(r), LW'(32'hDEAD_BEEF));
    check("rd40_no_fill", LW'(rd_cnt[0]), LW'(rd_before));

    // FIFO: dirty tag 0 in set 0, fill ways 1..3, then tag 4 forces a write-back.
    access(0, 0, 1, 32'h0, 32'hA5A5_A5A5, m, r);
    check("wr0_hit", LW'(m), LW'(0));
    access(0, 1, 0, 32'h100, 32'h0, m, r);
    access(0, 1, 0, 32'h200, 32'h0, m, r);
    access(0, 1, 0, 32'h300, 32'h0, m, r);
    check("fifo_wb_none_yet", LW'(wr_cnt[0]), LW'(0));
    access(0, 1, 0, 32'h400, 32'h0, m, r);
    exp_line = line_of(0, 10'h3FF);
    for (int k = 0; k < 8; k++) exp_line[32*k +: 32] = 32'hC000_0000 | 32'(k);
    exp_line[31:0] = 32'hA5A5_A5A5;
    check("fifo_t4_miss",    LW'(m), LW'(1));
    check("fifo_wb_count",   LW'(wr_cnt[0]), LW'(1));
    check("fifo_wb_addr",    LW'(last_wr_addr[0]), LW'(0));
    check("fifo_wb_line",    last_wr_line[0], exp_line);
    check("fifo_fill_addr",  LW'(last_rd_addr[0]), LW'(10'h020));
    check("fifo_t4_rd_data", LW'(r), LW'(32'hC000_2000));

    // Read and write together on a clean hit: read wins, word and dirty bit untouched.
    access(0, 1, 1, 32'h100, 32'h1234_5678, m, r);
    check("rdwr_hit",  LW'(m), LW'(0));
    check("rdwr_data", LW'(r), LW'(32'hC000_0800));
    access(0, 1, 0, 32'h100, 32'h0, m, r);
    check("rdwr_word_kept", LW'(r), LW'(32'hC000_0800));
    access(0, 1, 0, 32'h500, 32'h0, m, r);
    check("rdwr_clean_evict", LW'(wr_cnt[0]), LW'(1));

    // Pointer walks ways 2, 3 and wraps back to way 0.
    access(0, 1, 0, 32'h600, 32'h0, m, r);
    access(0, 1, 0, 32'h700, 32'h0, m, r);
    access(0, 1, 0, 32'h400, 32'h0, m, r);
    check("fifo_t4_still_hit", LW'(m), LW'(0));
    access(0, 1, 0, 32'h800, 32'h0, m, r);
    check("fifo_t8_miss", LW'(m), LW'(1));
    access(0, 1, 0, 32'h700, 32'h0, m, r);
    check("fifo_t7_hit", LW'(m), LW'(0));
    access(0, 1, 0, 32'h400, 32'h0, m, r);
    check("fifo_wrap_evicted_t4", LW'(m), LW'(1));

    // LRU: A..D fill set 0, A re-read, E evicts B.
    access(1, 1, 0, 32'h100, 32'h0, m, r);
    access(1, 1, 0, 32'h200, 32'h0, m, r);
    access(1, 1, 0, 32'h300, 32'h0, m, r);
    access(1, 1, 0, 32'h400, 32'h0, m, r);
    access(1, 1, 0, 32'h100, 32'h0, m, r);
    check("lru_a_rehit", LW'(m), LW'(0));
    access(1, 1, 0, 32'h500, 32'h0, m, r);
    check("lru_e_miss",      LW'(m), LW'(1));
    check("lru_e_fill_addr", LW'(last_rd_addr[1]), LW'(10'h028));
    check("lru_e_rd_data",   LW'(r), LW'(32'hC000_2800));
    access(1, 1, 0, 32'h100, 32'h0, m, r);
    check("lru_a_kept", LW'(m), LW'(0));
    access(1, 1, 0, 32'h400, 32'h0, m, r);
    check("lru_d_kept", LW'(m), LW'(0));
    access(1, 1, 0, 32'h200, 32'h0, m, r);
    check("lru_b_evicted", LW'(m), LW'(1));

    // Reset in the middle of a line fetch.
    @(negedge clk);
    addr_s[1] = 32'h900; rd_s[1] = 1'b1;
    n = 0;
    while (!mrd_s[1] && n < 50) begin @(negedge clk); n++; end
    check("rst_reach_swap_in", LW'(mrd_s[1]), LW'(1));
    rst = 1'b1;
    #1;
    check("rst_abort_mem_rd", LW'(mrd_s[1]), LW'(0));
    check("rst_abort_rd_data", LW'(rdd_s[1]), LW'(0));
    rd_s[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    access(1, 1, 0, 32'h100, 32'h0, m, r);
    check("rst_lines_invalid", LW'(m), LW'(1));
    check("rst_refill_data",   LW'(r), LW'(32'hC000_0800));

    check("mem_req_exclusive", LW'(both_hi), LW'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cache_assoc.md
Name: cache_assoc

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache for the CacheLab CPU datapath.
- Successor to the direct-mapped/fixed-way cache, with these additions:
  - Replacement policy selectable by parameter (FIFO or true LRU), with sequential replacement state.
  - Invalid ways are filled before any eviction.
  - Main-memory line port exposed at the boundary instead of instantiated inside, so the bench or top level attaches main_mem.

Parameters:
- LINE_ADDR_LEN, 3: log2 words per line.
- SET_ADDR_LEN, 3: log2 number of sets.
- TAG_ADDR_LEN, 7: tag width in bits.
- WAY_CNT, 4: ways per set, 1..16.
- REPL_POLICY, 0: 0 = FIFO, 1 = LRU.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- addr  in  32  byte address, split as {unused, tag, set, line, word[1:0]}
- rd_req  in  1  read request
- wr_req  in  1  write request
- wr_data  in  32  write word
- rd_data  out  32  read word, registered
- miss  out  1  request outstanding or not yet served
- mem_addr  out  TAG_ADDR_LEN+SET_ADDR_LEN  line address {tag, set}
- mem_rd_req  out  1  line fill request
- mem_wr_req  out  1  line write-back request
- mem_wr_line  out  32*2^LINE_ADDR_LEN  victim line; word k at bits [32k+31:32k]
- mem_rd_line  in  32*2^LINE_ADDR_LEN  filled line, same packing
- mem_gnt  in  1  single-cycle memory completion pulse

Behaviour:
- Reset, asynchronous, effective immediately:
  - state = IDLE; every valid = 0 and dirty = 0; rd_data = 0.
  - mem_rd_req = 0, mem_wr_req = 0, mem_addr = 0, mem_wr_line = 0.
  - FIFO pointer of each set = 0; LRU age[set][w] = w (way 0 is oldest).
  - Reset during SWAP_* aborts the transfer; memory requests drop in the same cycle.
- Hit = valid && tag match in exactly one way (combinational). Lookup uses live addr only in IDLE.
- miss = (rd_req | wr_req) & ~(hit & state == IDLE). miss is combinational.
- rd_req has priority over wr_req when both are asserted.
- Requestor holds addr, rd_req, wr_req and wr_data stable until miss = 0.
- IDLE, read hit: rd_data <= word at the next edge (latency 1). Way is marked most recently used.
- IDLE, write hit: word written and dirty set at the next edge. Way is marked most recently used.
- IDLE, miss with a request: latch tag/set and victim way.
  - Victim is the lowest-index invalid way if any; otherwise FIFO pointer (FIFO) or oldest age (LRU).
  - Valid && dirty victim: go to SWAP_OUT, latching the victim line and {victim tag, set}.
  - Otherwise go to SWAP_IN.
- SWAP_OUT: mem_wr_req = 1, mem_addr = victim address. On mem_gnt, go to SWAP_IN.
- SWAP_IN: mem_rd_req = 1, mem_addr = latched {tag, set}. On mem_gnt, capture mem_rd_line and go to SWAP_IN_OK.
- SWAP_IN_OK, one cycle:
  - Write line, tag, valid = 1, dirty = 0 into the victim way.
  - Mark victim most recently used.
  - FIFO pointer of the set increments, wrapping at WAY_CNT-1 to 0, only if the victim was chosen by policy. Invalid-way fills leave it unchanged.
  - Return to IDLE. The held request then hits, so a write miss completes one cycle later.
- LRU update: the touched way gets age WAY_CNT-1. Ways younger than its old age decrement by 1; others are unchanged.
- FIFO state is unchanged on hits.
- mem_rd_req and mem_wr_req are never high together. Both are 0 in IDLE and SWAP_IN_OK.
- No request in IDLE: no state change.

Optional Feature:
- Macro CACHE_STATS_EN.
- Defined:
  - Adds outputs hit_cnt and miss_cnt, 32 bits each, reset to 0, saturating at 0xFFFFFFFF.
  - hit_cnt increments on each IDLE cycle that serves a hit.
  - miss_cnt increments on each IDLE to SWAP_* transition.
- Undefined: no ports and no logic; behaviour otherwise identical.

Decomposition:
- Package cache_pkg:
  - State enum cache_state_t {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK}.
  - Policy constants REPL_FIFO = 0 and REPL_LRU = 1.
  - Localparam helpers for line size and memory address width.
- Sub-module cache_repl:
  - Holds per-set FIFO pointers and LRU ages; outputs the victim way for a set.
  - Inputs: touch (way, set), fill (way, set, by_policy).

Test Plan:
- Reset, then read 0x0000_0000 with WAY_CNT = 4 -> miss = 1, SWAP_IN, mem_addr = 0. After fill, rd_data = mem word 0 one cycle after miss falls.
- Write 0xDEADBEEF to 0x40, then read 0x40 -> second access hits with no memory traffic; rd_data = 0xDEADBEEF.
- FIFO policy: five distinct tags into set 0, first one dirtied -> fifth miss issues SWAP_OUT with the tag-0 address and line, then SWAP_IN; pointer wraps 3 -> 0.
- LRU policy: fill ways with tags A, B, C, D, re-read A, miss on E -> B is evicted; A still hits.
- rd_req and wr_req both high on a hit -> read served, cache word unchanged, dirty unchanged.
- Assert rst during SWAP_IN -> mem_rd_req = 0 immediately, all lines invalid, the next read misses.
